// File: rtl/cafe_pkg.sv
// Shared definitions for the coffee machine credit path: FSM states of the
// change dispenser and coin values expressed in 100-unit steps.
package cafe_pkg;

    localparam int N_DEF     = 4;
    localparam int VALOR_500 = 5;
    localparam int VALOR_100 = 1;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        VERIFICA = 3'd1,
        ENTREGA  = 3'd2,
        VUELTO   = 3'd3,
        ESPERA   = 3'd4,
        FIN      = 3'd5
    } estado_vuelto_t;

endpackage

// File: rtl/devolucion_vuelto_if.sv
// Purchase/change bundle between the dispenser FSM, the credit counter,
// the front panel and the coin ejector.
interface devolucion_vuelto_if #(
    parameter int N = 4
);
    logic [N-1:0] credito;
    logic [N-1:0] precio;
    logic         iniciar;
    logic         expulsor_listo;
    logic         ocupado;
    logic         producto;
    logic         pedido500;
    logic         pedido100;
    logic         error;
    logic         hecho;
    logic         limpiar;
    logic [N-1:0] resto;

    modport master (
        output credito, precio, iniciar, expulsor_listo,
        input  ocupado, producto, pedido500, pedido100, error, hecho, limpiar, resto
    );

    modport slave (
        input  credito, precio, iniciar, expulsor_listo,
        output ocupado, producto, pedido500, pedido100, error, hecho, limpiar, resto
    );
endinterface

// File: rtl/devolucion_vuelto.sv
// Charges the product price against the accumulated credit, pulses the
// dispenser, then returns change greedily (500s first, then 100s) via req/ack.
module devolucion_vuelto
    import cafe_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int VALOR_500 = cafe_pkg::VALOR_500
) (
    input  logic              clk,
    input  logic              reset,
    devolucion_vuelto_if.slave bus
);

    localparam logic [2:0] ST_REPOSO   = 3'(REPOSO);
    localparam logic [2:0] ST_VERIFICA = 3'(VERIFICA);
    localparam logic [2:0] ST_ENTREGA  = 3'(ENTREGA);
    localparam logic [2:0] ST_VUELTO   = 3'(VUELTO);
    localparam logic [2:0] ST_ESPERA   = 3'(ESPERA);
    localparam logic [2:0] ST_FIN      = 3'(FIN);

    localparam logic [N-1:0] PASO_500 = N'(VALOR_500);
    localparam logic [N-1:0] PASO_100 = N'(VALOR_100);

    logic [2:0]   estado;
    logic [N-1:0] credito_r;
    logic [N-1:0] precio_r;
    logic [N-1:0] resto_r;
    logic         error_r;
    logic         sel500;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= ST_REPOSO;
            credito_r <= '0;
            precio_r  <= '0;
            resto_r   <= '0;
            error_r   <= 1'b0;
            sel500    <= 1'b0;
        end else begin
            case (estado)
                ST_REPOSO: begin
                    if (bus.iniciar) begin
                        credito_r <= bus.credito;
                        precio_r  <= bus.precio;
                        error_r   <= 1'b0;
                        estado    <= ST_VERIFICA;
                    end
                end
                ST_VERIFICA: begin
                    // Short credit refunds everything and skips the dispenser.
                    if (credito_r < precio_r) begin
                        error_r <= 1'b1;
                        resto_r <= credito_r;
                        estado  <= ST_VUELTO;
                    end else begin
                        resto_r <= credito_r - precio_r;
                        estado  <= ST_ENTREGA;
                    end
                end
                ST_ENTREGA: estado <= ST_VUELTO;
                ST_VUELTO: begin
                    if (resto_r == '0) begin
                        estado <= ST_FIN;
                    end else begin
                        sel500 <= (resto_r >= PASO_500);
                        estado <= ST_ESPERA;
                    end
                end
                ST_ESPERA: begin
                    // The selected coin never exceeds resto, so no wrap here.
                    if (bus.expulsor_listo) begin
                        resto_r <= resto_r - (sel500 ? PASO_500 : PASO_100);
                        estado  <= ST_VUELTO;
                    end
                end
                ST_FIN:  estado <= ST_REPOSO;
                default: estado <= ST_REPOSO;
            endcase
        end
    end

    assign bus.ocupado   = (estado != ST_REPOSO);
    assign bus.producto  = (estado == ST_ENTREGA);
    assign bus.pedido500 = (estado == ST_ESPERA) &&  sel500;
    assign bus.pedido100 = (estado == ST_ESPERA) && !sel500;
    assign bus.hecho     = (estado == ST_FIN);
    assign bus.limpiar   = (estado == ST_FIN);
    assign bus.error     = error_r;
    assign bus.resto     = resto_r;

endmodule

// File: tb/tb_devolucion_vuelto.sv
// Directed bench for devolucion_vuelto: exact payment, change, refund,
// ejector stall, mid-transaction reset, ignored iniciar and max credit.
module tb_devolucion_vuelto;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    devolucion_vuelto_if #(.N(4)) bus ();

    devolucion_vuelto #(.N(4), .VALOR_500(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_prod, prod_cyc, hecho_cyc, both, n_coins, max_resto;
    int          coin_v [8];
    int          resto_v[8];
    logic        err_h, limp_h;
    int          resto_h;
    bit          timeout;

    // Follows one transaction from the acceptance edge until hecho; cycle 1 is VERIFICA.
    task automatic observe(input int poke);
        logic p500_q, p100_q;
        n_prod = 0; prod_cyc = 0; hecho_cyc = 0; both = 0; n_coins = 0; max_resto = 0;
        err_h = 0; limp_h = 0; resto_h = -1; timeout = 1; p500_q = 0; p100_q = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) bus.iniciar = 1'b0;
            if (poke != 0 && c == poke) begin bus.iniciar = 1'b1; bus.credito = 4'd15; end
            if (poke != 0 && c == poke + 2) bus.iniciar = 1'b0;
            if (bus.producto) begin n_prod++; prod_cyc = c; end
            if (bus.pedido500 && bus.pedido100) both++;
            if (c >= 2 && int'(bus.resto) > max_resto) max_resto = int'(bus.resto);
            if ((bus.pedido500 && !p500_q) || (bus.pedido100 && !p100_q)) begin
                if (n_coins < 8) begin
                    coin_v[n_coins]  = bus.pedido500 ? 5 : 1;
                    resto_v[n_coins] = int'(bus.resto);
                end
                n_coins++;
            end
            p500_q = bus.pedido500;
            p100_q = bus.pedido100;
            if (bus.hecho) begin
                hecho_cyc = c; err_h = bus.error; limp_h = bus.limpiar;
                resto_h = int'(bus.resto); timeout = 0;
                break;
            end
        end
    endtask

    task automatic start(input logic [3:0] cr, input logic [3:0] pr, input logic ack);
        bus.credito = cr; bus.precio = pr; bus.expulsor_listo = ack; bus.iniciar = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({bus.ocupado, bus.producto, bus.pedido500, bus.pedido100, bus.hecho, bus.limpiar, bus.error} !== 7'b0) begin
            failures++; $display("FAIL reset_outputs got %b want 0000000", {bus.ocupado, bus.producto, bus.pedido500, bus.pedido100, bus.hecho, bus.limpiar, bus.error}); end
        checks++; if (bus.resto !== 4'd0) begin failures++; $display("FAIL reset_resto got %0d want 0", bus.resto); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exacto;
        start(4'd3, 4'd3, 1'b1);
        observe(0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL exacto_timeout got %0d want 0", timeout); end
        checks++; if (n_prod !== 1) begin failures++; $display("FAIL exacto_nprod got %0d want 1", n_prod); end
        checks++; if (prod_cyc !== 2) begin failures++; $display("FAIL exacto_prod_cycle got %0d want 2", prod_cyc); end
        checks++; if (hecho_cyc !== 4) begin failures++; $display("FAIL exacto_hecho_cycle got %0d want 4", hecho_cyc); end
        checks++; if (n_coins !== 0) begin failures++; $display("FAIL exacto_coins got %0d want 0", n_coins); end
        checks++; if (limp_h !== 1'b1) begin failures++; $display("FAIL exacto_limpiar got %0d want 1", limp_h); end
        checks++; if (err_h !== 1'b0) begin failures++; $display("FAIL exacto_error got %0d want 0", err_h); end
        @(negedge clk);
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL exacto_ocupado_after got %0d want 0", bus.ocupado); end
    endtask

    task automatic test_cambio;
        start(4'd13, 4'd2, 1'b1);
        observe(0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL cambio_timeout got %0d want 0", timeout); end
        checks++; if (n_prod !== 1) begin failures++; $display("FAIL cambio_nprod got %0d want 1", n_prod); end
        checks++; if (n_coins !== 3) begin failures++; $display("FAIL cambio_ncoins got %0d want 3", n_coins); end
        checks++; if ({coin_v[0], coin_v[1], coin_v[2]} !== {32'd5, 32'd5, 32'd1}) begin
            failures++; $display("FAIL cambio_coins got %0d,%0d,%0d want 5,5,1", coin_v[0], coin_v[1], coin_v[2]); end
        checks++; if ({resto_v[0], resto_v[1], resto_v[2]} !== {32'd11, 32'd6, 32'd1}) begin
            failures++; $display("FAIL cambio_resto_seq got %0d,%0d,%0d want 11,6,1", resto_v[0], resto_v[1], resto_v[2]); end
        checks++; if (hecho_cyc !== 10) begin failures++; $display("FAIL cambio_hecho_cycle got %0d want 10", hecho_cyc); end
        checks++; if (resto_h !== 0) begin failures++; $display("FAIL cambio_resto_end got %0d want 0", resto_h); end
        checks++; if (both !== 0) begin failures++; $display("FAIL cambio_both_pedidos got %0d want 0", both); end
        checks++; if (err_h !== 1'b0) begin failures++; $display("FAIL cambio_error got %0d want 0", err_h); end
        @(negedge clk);
    endtask

    task automatic test_error;
        start(4'd2, 4'd4, 1'b1);
        observe(0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL error_timeout got %0d want 0", timeout); end
        checks++; if (n_prod !== 0) begin failures++; $display("FAIL error_nprod got %0d want 0", n_prod); end
        checks++; if (n_coins !== 2) begin failures++; $display("FAIL error_ncoins got %0d want 2", n_coins); end
        checks++; if ({coin_v[0], coin_v[1], resto_v[0], resto_v[1]} !== {32'd1, 32'd1, 32'd2, 32'd1}) begin
            failures++; $display("FAIL error_refund got coins %0d,%0d resto %0d,%0d want 1,1 2,1", coin_v[0], coin_v[1], resto_v[0], resto_v[1]); end
        checks++; if (hecho_cyc !== 7) begin failures++; $display("FAIL error_hecho_cycle got %0d want 7", hecho_cyc); end
        checks++; if (err_h !== 1'b1) begin failures++; $display("FAIL error_at_hecho got %0d want 1", err_h); end
        repeat (3) @(negedge clk);
        checks++; if ({bus.ocupado, bus.error} !== 2'b01) begin
            failures++; $display("FAIL error_sticky_idle got ocupado=%0d error=%0d want 0 1", bus.ocupado, bus.error); end
    endtask

    task automatic test_espera;
        start(4'd6, 4'd0, 1'b0);
        @(negedge clk); bus.iniciar = 1'b0;
        checks++; if ({bus.ocupado, bus.error} !== 2'b10) begin
            failures++; $display("FAIL espera_verifica got ocupado=%0d error=%0d want 1 0", bus.ocupado, bus.error); end
        @(negedge clk);
        checks++; if (bus.producto !== 1'b1) begin failures++; $display("FAIL espera_producto got %0d want 1", bus.producto); end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++; if ({bus.pedido500, bus.pedido100, bus.resto} !== {2'b10, 4'd6}) begin
                failures++; $display("FAIL espera_hold_%0d got p500=%0d p100=%0d resto=%0d want 1 0 6", i, bus.pedido500, bus.pedido100, bus.resto); end
            if (i == 5) bus.expulsor_listo = 1'b1;
            @(negedge clk);
        end
        checks++; if ({bus.pedido500, bus.resto} !== {1'b0, 4'd1}) begin
            failures++; $display("FAIL espera_after_ack got p500=%0d resto=%0d want 0 1", bus.pedido500, bus.resto); end
        @(negedge clk);
        checks++; if ({bus.pedido500, bus.pedido100} !== 2'b01) begin
            failures++; $display("FAIL espera_p100 got p500=%0d p100=%0d want 0 1", bus.pedido500, bus.pedido100); end
        @(negedge clk);
        checks++; if (bus.resto !== 4'd0) begin failures++; $display("FAIL espera_resto_zero got %0d want 0", bus.resto); end
        @(negedge clk);
        checks++; if ({bus.hecho, bus.limpiar} !== 2'b11) begin
            failures++; $display("FAIL espera_hecho got hecho=%0d limpiar=%0d want 1 1", bus.hecho, bus.limpiar); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        start(4'd6, 4'd9, 1'b0);
        @(negedge clk); bus.iniciar = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({bus.pedido500, bus.error, bus.resto} !== {2'b11, 4'd6}) begin
            failures++; $display("FAIL rmid_before got p500=%0d error=%0d resto=%0d want 1 1 6", bus.pedido500, bus.error, bus.resto); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({bus.pedido500, bus.ocupado, bus.error, bus.resto} !== 7'b0) begin
            failures++; $display("FAIL rmid_after got p500=%0d ocupado=%0d error=%0d resto=%0d want 0 0 0 0", bus.pedido500, bus.ocupado, bus.error, bus.resto); end
        start(4'd3, 4'd3, 1'b1);
        @(negedge clk);
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL reset_beats_iniciar got ocupado=%0d want 0", bus.ocupado); end
        reset = 1'b0; bus.iniciar = 1'b0;
        @(negedge clk);
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL reset_iniciar_dropped got ocupado=%0d want 0", bus.ocupado); end
    endtask

    task automatic test_iniciar_ignorado;
        start(4'd3, 4'd1, 1'b1);
        observe(3);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL ign_timeout got %0d want 0", timeout); end
        checks++; if ({n_prod, n_coins} !== {32'd1, 32'd2}) begin
            failures++; $display("FAIL ign_counts got prod=%0d coins=%0d want 1 2", n_prod, n_coins); end
        checks++; if ({coin_v[0], coin_v[1], resto_v[0], resto_v[1]} !== {32'd1, 32'd1, 32'd2, 32'd1}) begin
            failures++; $display("FAIL ign_change got coins %0d,%0d resto %0d,%0d want 1,1 2,1", coin_v[0], coin_v[1], resto_v[0], resto_v[1]); end
        checks++; if (hecho_cyc !== 8) begin failures++; $display("FAIL ign_hecho_cycle got %0d want 8", hecho_cyc); end
        repeat (2) @(negedge clk);
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL ign_no_restart got ocupado=%0d want 0", bus.ocupado); end
    endtask

    task automatic test_maximo;
        start(4'd15, 4'd0, 1'b1);
        observe(0);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL max_timeout got %0d want 0", timeout); end
        checks++; if ({n_coins, coin_v[0], coin_v[1], coin_v[2]} !== {32'd3, 32'd5, 32'd5, 32'd5}) begin
            failures++; $display("FAIL max_coins got n=%0d %0d,%0d,%0d want 3 5,5,5", n_coins, coin_v[0], coin_v[1], coin_v[2]); end
        checks++; if ({resto_v[0], resto_v[1], resto_v[2]} !== {32'd15, 32'd10, 32'd5}) begin
            failures++; $display("FAIL max_resto_seq got %0d,%0d,%0d want 15,10,5", resto_v[0], resto_v[1], resto_v[2]); end
        checks++; if ({max_resto, resto_h} !== {32'd15, 32'd0}) begin
            failures++; $display("FAIL max_no_wrap got max=%0d end=%0d want 15 0", max_resto, resto_h); end
        checks++; if (hecho_cyc !== 10) begin failures++; $display("FAIL max_hecho_cycle got %0d want 10", hecho_cyc); end
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; checks = 0; failures = 0;
        bus.credito = '0; bus.precio = '0; bus.iniciar = 1'b0; bus.expulsor_listo = 1'b0;
        test_reset;
        test_exacto;
        test_cambio;
        test_error;
        test_espera;
        test_reset_mid;
        test_iniciar_ignorado;
        test_maximo;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
